// File: rtl/aes_pkg.sv
// Shared AES constants and helpers used by the key schedule and the encryption core.
package aes_pkg;

   localparam int unsigned NR     = 10;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned RK_W   = 128;

   localparam logic [3:0] RND_LAST = 4'(NR);

   typedef enum logic {IDLE, EXPAND} ks_state_t;

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] r;
      case (rnd)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared with the SubBytes path.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   always_comb begin
      out_byte = 8'h00;
      case (in_byte)
         8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77;
         8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b;
         8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5; 8'h08: out_byte = 8'h30;
         8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b;
         8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab;
         8'h0f: out_byte = 8'h76; 8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82;
         8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa;
         8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
         8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2;
         8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4;
         8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0; 8'h20: out_byte = 8'hb7;
         8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26;
         8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7;
         8'h27: out_byte = 8'hcc; 8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5;
         8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71;
         8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
         8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23;
         8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96;
         8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a; 8'h38: out_byte = 8'h07;
         8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2;
         8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2;
         8'h3f: out_byte = 8'h75; 8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83;
         8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b;
         8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
         8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6;
         8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3;
         8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84; 8'h50: out_byte = 8'h53;
         8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed;
         8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1;
         8'h57: out_byte = 8'h5b; 8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb;
         8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a;
         8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
         8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa;
         8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d;
         8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85; 8'h68: out_byte = 8'h45;
         8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f;
         8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f;
         8'h6f: out_byte = 8'ha8; 8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3;
         8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92;
         8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
         8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda;
         8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff;
         8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2; 8'h80: out_byte = 8'hcd;
         8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec;
         8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44;
         8'h87: out_byte = 8'h17; 8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7;
         8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64;
         8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
         8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f;
         8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a;
         8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88; 8'h98: out_byte = 8'h46;
         8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14;
         8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b;
         8'h9f: out_byte = 8'hdb; 8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32;
         8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49;
         8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
         8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac;
         8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95;
         8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79; 8'hb0: out_byte = 8'he7;
         8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d;
         8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e;
         8'hb7: out_byte = 8'ha9; 8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56;
         8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65;
         8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
         8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25;
         8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6;
         8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6; 8'hc8: out_byte = 8'he8;
         8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f;
         8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b;
         8'hcf: out_byte = 8'h8a; 8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e;
         8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48;
         8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
         8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57;
         8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1;
         8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e; 8'he0: out_byte = 8'he1;
         8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11;
         8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e;
         8'he7: out_byte = 8'h94; 8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e;
         8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce;
         8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
         8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89;
         8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6;
         8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68; 8'hf8: out_byte = 8'h41;
         8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f;
         8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb;
         8'hff: out_byte = 8'h16;
      endcase
   end

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file,
// read back through a combinational indexed port.
module aes128_key_expand
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [RK_W-1:0] key_in,
   output logic            ready,
   output logic            done,
   output logic            keys_valid,
   input  logic [3:0]      rk_idx,
   output logic [RK_W-1:0] rk_out
);

   ks_state_t       state, state_d;
   logic [3:0]      rnd;
   logic [RK_W-1:0] rk [0:NR];

   logic [3:0]        prev_idx;
   logic [RK_W-1:0]   prev_rk;
   logic [WORD_W-1:0] w0, w1, w2, w3;
   logic [WORD_W-1:0] rot_w, sub_w, t;
   logic [WORD_W-1:0] n0, n1, n2, n3;
   logic [RK_W-1:0]   next_rk;

   assign ready = (state == IDLE);

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = EXPAND;
         EXPAND:  if (rnd == RND_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Round function on the previous round key.
   assign prev_idx = rnd - 4'd1;

   always_comb begin
      prev_rk = '0;
      if (prev_idx <= RND_LAST) prev_rk = rk[prev_idx];
   end

   assign {w0, w1, w2, w3} = prev_rk;
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (rot_w[8*g +: 8]),
         .out_byte (sub_w[8*g +: 8])
      );
   end

   assign t  = sub_w ^ {rcon(rnd), 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign next_rk = {n0, n1, n2, n3};

   always_ff @(posedge clk) begin
      if (rst) begin
         rnd        <= 4'd0;
         done       <= 1'b0;
         keys_valid <= 1'b0;
         for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rk[0]      <= key_in;
                  rnd        <= 4'd1;
                  keys_valid <= 1'b0;
               end
            end
            EXPAND: begin
               rk[rnd] <= next_rk;
               if (rnd == RND_LAST) begin
                  rnd        <= 4'd0;
                  keys_valid <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rk_out = '0;
      if (rk_idx <= RND_LAST) rk_out = rk[rk_idx];
   end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Scoreboard bench: stimulus queues expected schedules, a monitor checks them on each done pulse.
module tb_aes128_key_expand;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         ready;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;

   logic [3:0] stim_idx;
   logic [3:0] mon_idx;
   logic       mon_active;
   int         cyc;
   int         checks;
   int         errors;

   typedef struct {
      logic [127:0] k0;
      logic [127:0] r1;
      logic [127:0] r10;
      int           acc;
   } exp_t;

   exp_t sb[$];

   localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] R1_SEQ   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] R10_SEQ  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] KEY_ZERO = 128'h0;
   localparam logic [127:0] R1_ZERO  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] R10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   assign rk_idx = mon_active ? mon_idx : stim_idx;

   aes128_key_expand dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .ready      (ready),
      .done       (done),
      .keys_valid (keys_valid),
      .rk_idx     (rk_idx),
      .rk_out     (rk_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, exp);
      end
   endtask

   // Monitor: on every done pulse, pop the oldest expected schedule and compare.
   initial begin
      exp_t e;
      mon_active = 1'b0;
      mon_idx    = 4'd0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done got done=1 want no done");
            end else begin
               e = sb.pop_front();
               chk_int("done_latency", cyc - e.acc, 10);
               chk1("keys_valid_at_done", keys_valid, 1'b1);
               chk1("ready_at_done", ready, 1'b1);
               mon_active = 1'b1;
               mon_idx = 4'd0;
               #1 chk128("rk0", rk_out, e.k0);
               mon_idx = 4'd1;
               #1 chk128("rk1", rk_out, e.r1);
               mon_idx = 4'd10;
               #1 chk128("rk10", rk_out, e.r10);
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic do_start(input logic [127:0] k, input logic [127:0] r1,
                           input logic [127:0] r10);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      key_in = k;
      @(posedge clk);
      #1;
      start  = 1'b0;
      key_in = ~k;
      e.k0 = k;
      e.r1 = r1;
      e.r10 = r10;
      e.acc = cyc;
      sb.push_back(e);
      chk1("ready_after_accept", ready, 1'b0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ready !== 1'b1 && n < 20);
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout got ready=%b want 1 within 20 cycles", ready);
      end
      @(negedge clk);
      chk1("done_single_pulse", done, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish before 200us");
      $fatal(1);
   end

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      key_in   = '0;
      stim_idx = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk1("reset_ready", ready, 1'b1);
      chk1("reset_done", done, 1'b0);
      chk1("reset_keys_valid", keys_valid, 1'b0);
      chk128("reset_rk_out", rk_out, 128'h0);

      do_start(KEY_FIPS, R1_FIPS, R10_FIPS);
      wait_idle();

      do_start(KEY_SEQ, R1_SEQ, R10_SEQ);
      wait_idle();
      chk1("seq_keys_valid", keys_valid, 1'b1);

      do_start(KEY_ZERO, R1_ZERO, R10_ZERO);
      wait_idle();
      stim_idx = 4'd12;
      #1 chk128("rk_idx12_zero", rk_out, 128'h0);
      stim_idx = 4'd15;
      #1 chk128("rk_idx15_zero", rk_out, 128'h0);
      stim_idx = 4'd0;

      // Second start at E4 must be ignored entirely.
      do_start(KEY_FIPS, R1_FIPS, R10_FIPS);
      repeat (3) @(posedge clk);
      @(negedge clk);
      start  = 1'b1;
      key_in = KEY_ZERO;
      @(posedge clk);
      #1 start = 1'b0;
      chk1("busy_ready_low", ready, 1'b0);
      wait_idle();

      // Restart from a valid schedule: keys_valid stays low until done.
      chk1("restart_pre_valid", keys_valid, 1'b1);
      do_start(KEY_ZERO, R1_ZERO, R10_ZERO);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk1("restart_keys_valid_low", keys_valid, 1'b0);
      end
      wait_idle();

      // Reset at E5, with a coincident start that must be ignored.
      do_start(KEY_FIPS, R1_FIPS, R10_FIPS);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst    = 1'b1;
      start  = 1'b1;
      key_in = KEY_SEQ;
      @(posedge clk);
      #1;
      sb.delete();
      chk1("midrst_ready", ready, 1'b1);
      chk1("midrst_keys_valid", keys_valid, 1'b0);
      chk1("midrst_done", done, 1'b0);
      for (int i = 0; i < 16; i++) begin
         stim_idx = 4'(i);
         #1 chk128("midrst_rk_zero", rk_out, 128'h0);
      end
      stim_idx = 4'd0;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk1("postrst_ready", ready, 1'b1);
      chk128("postrst_rk0_zero", rk_out, 128'h0);

      do_start(KEY_SEQ, R1_SEQ, R10_SEQ);
      wait_idle();

      repeat (3) @(posedge clk);
      #1 chk_int("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes128_key_expand.md
# aes128_key_expand

Iterative AES-128 key schedule, directly upstream of the AES-128 encryption datapath. Accepts a 128-bit cipher key on a start strobe, derives the 11 FIPS-197 round keys at one round key per clock, and holds them in an internal register file. The encryption stage reads any round key through an indexed port, so the S-box-heavy expansion leaves the cipher datapath and the key can be loaded once and reused across many blocks.

## Interface

- NR, 10: number of rounds, fixed for AES-128; round-key indices run 0..NR.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high; the only reset.
- start  in  1  request expansion of key_in; honoured only when ready=1.
- key_in  in  128  cipher key, big-endian byte order (byte 0 = bits 127:120), sampled on the accepting edge only.
- ready  out  1  1 = idle, start will be accepted.
- done  out  1  one-cycle pulse, expansion complete.
- keys_valid  out  1  1 = all 11 round keys hold the most recently accepted key's schedule.
- rk_idx  in  4  round-key read index.
- rk_out  out  128  round key rk[rk_idx]; combinational read.

## Operation

- States: IDLE, EXPAND. A 4-bit round counter rnd and an 11 x 128 register file rk[0..10].
- IDLE: ready=1. When start=1 on an edge: rk[0] <= key_in, rnd <= 1, keys_valid <= 0, state -> EXPAND.
- EXPAND: ready=0. On each edge, rk[rnd] <= f(rk[rnd-1], rcon[rnd]) and rnd <= rnd+1.
  - With w0..w3 the 32-bit words of rk[rnd-1], w0 in the MSBs: t = SubWord(RotWord(w3)) XOR {rcon, 24'h0}; w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord is a left rotate by one byte. rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- On the edge that writes rk[10] (rnd=10): state -> IDLE, keys_valid <= 1, done <= 1, rnd <= 0.
- done is cleared on every other edge.
- start while in EXPAND is ignored. It is not queued, and key_in changes are ignored.
- start in IDLE while keys_valid=1 restarts expansion: keys_valid drops on the accepting edge.
- rk_out = rk[rk_idx] for rk_idx 0..10. For rk_idx 11..15, rk_out = 0.
- rk_out may be read during EXPAND, but its contents are only guaranteed when keys_valid=1.
- Reset, including mid-EXPAND:
  - state=IDLE, rnd=0, all rk[] cleared to 0.
  - ready=1, done=0, keys_valid=0; rk_out therefore reads 0.
  - A start in the same cycle as rst is ignored.

## Timing

- Acceptance edge E0 writes rk[0]. Edges E1..E10 write rk[1]..rk[10].
- done and keys_valid are high in the cycle after E10. Latency is 10 clocks from the accepting edge to done.
- ready falls after E0 and returns after E10. The earliest next acceptance is E11, so back-to-back expansions are 11 clocks apart.
- rk_out has zero-cycle latency from rk_idx: a mux only, with no register on the read path.
- Critical path: 4 S-boxes, then the rcon XOR, then a 4-deep XOR chain, into the rk write.

## Structure

- Shared package aes_pkg holds:
  - NR;
  - the rcon lookup as a function of round index;
  - the word and round-key width constants.
- The encryption core reuses aes_pkg.
- Sub-module aes_sbox: 8-bit combinational forward S-box (256-entry case).
  - Instantiated 4x here, on RotWord(w3).
  - Shared with the encryption SubBytes path.
- The FSM, counter, register file and read mux stay in aes128_key_expand.

## Test plan

- Key 2b7e151628aed2a6abf7158809cf4f3c, start for 1 cycle -> done exactly 10 clocks after acceptance. Then rk_idx=1 -> a0fafe1788542cb123a339392a6c7605, and rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key 000102030405060708090a0b0c0d0e0f -> rk[0] = key; rk[10] = 13111d7fe3944a17f307a78b4d2b30c5; keys_valid=1.
- Key all-zero -> rk[1] = 62636363626363636263636362636363 and rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e. Then rk_idx=12 -> rk_out = 0.
- Busy-start check:
  - Stimulus: start with the FIPS key, then at E4 pulse start again with the zero key.
  - Required response: the second start is ignored; done follows 10 clocks after the first acceptance; rk[10] = d014f9a8…0ca6.
- Reset check:
  - Stimulus: assert rst at E5 of an expansion.
  - Required response: the next cycle shows ready=1, keys_valid=0, done=0, and rk_out=0 for all indices; a fresh start afterwards produces the correct schedule.
- Restart check:
  - Stimulus: with keys_valid=1 from key A, accept key B.
  - Required response: keys_valid=0 from the cycle after acceptance until done; final rk[10] matches key B.
